// File: rtl/lr_car_detector.sv
// Local-road vehicle detector: debounces the loop sensor, counts queued cars, and drains them on green.
// Latency: 2-flop sync + DEBOUNCE samples to an arrival (count at edge k+4 for DEBOUNCE=3); lr_has_car is decoded from the count register.
// Backpressure: none; an arrival at a saturated count is dropped and raises the sticky overflow flag.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   sensor         raw asynchronous loop sensor (1 = vehicle over loop)
//   lr_light       local-road light from the controller (3'b100 green)
//   lr_has_car     1 while car_count != 0
//   car_count      cars currently queued, saturating at 2**QW-1
//   arrival_pulse  one-cycle strobe per accepted car
//   overflow       sticky: an arrival was dropped at saturation
module lr_car_detector #(
    parameter int DEBOUNCE      = 3,
    parameter int DEPART_CYCLES = 2,
    parameter int QW            = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sensor,
    input  logic [2:0]    lr_light,
    output logic          lr_has_car,
    output logic [QW-1:0] car_count,
    output logic          arrival_pulse,
    output logic          overflow
);

    localparam logic [3:0]    DEB_N    = 4'(DEBOUNCE);
    localparam logic [3:0]    DEP_LAST = 4'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0] QMAX     = {QW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        PRESENT,
        RELEASE
    } state_t;

    logic          s1_q, s2_q;
    state_t        state_q, state_d;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    dep_q, dep_d;
    logic [QW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pulse_q;
    logic          arr;
    logic          dep;
    logic          green;
    logic          has_car;

    // Two-flop synchroniser; s2_q is the only sensor view used below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sensor;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM: one accepted arrival per vehicle, symmetric filtering on release.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        arr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = PRESENT;
                        deb_d   = 4'd0;
                        arr     = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                        deb_d   = 4'd1;
                    end
                end
            end
            CONFIRM: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    deb_d   = 4'd0;
                end else if (deb_q + 4'd1 == DEB_N) begin
                    state_d = PRESENT;
                    deb_d   = 4'd0;
                    arr     = 1'b1;
                end else begin
                    deb_d = deb_q + 4'd1;
                end
            end
            PRESENT: begin
                if (!s2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = IDLE;
                        deb_d   = 4'd0;
                    end else begin
                        state_d = RELEASE;
                        deb_d   = 4'd1;
                    end
                end
            end
            RELEASE: begin
                if (s2_q) begin
                    // Vehicle still there after a short dip: no new arrival.
                    state_d = PRESENT;
                    deb_d   = 4'd0;
                end else if (deb_q + 4'd1 == DEB_N) begin
                    state_d = IDLE;
                    deb_d   = 4'd0;
                end else begin
                    deb_d = deb_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = 4'd0;
            end
        endcase
    end

    // Departure timer: runs only on green with cars queued, restarts after each departure.
    assign green   = (lr_light == 3'b100);
    assign has_car = (count_q != '0);
    assign dep     = green && has_car && (dep_q == DEP_LAST);

    always_comb begin
        dep_d = dep_q + 4'd1;
        if (!green || !has_car || dep) begin
            dep_d = 4'd0;
        end
    end

    // Simultaneous arrival and departure cancel and never touch overflow.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        case ({arr, dep})
            2'b10: begin
                if (count_q == QMAX) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            deb_q   <= 4'd0;
            dep_q   <= 4'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            dep_q   <= dep_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            pulse_q <= arr;
        end
    end

    assign car_count     = count_q;
    assign lr_has_car    = has_car;
    assign arrival_pulse = pulse_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_lr_car_detector.sv
// Testbench for lr_car_detector: per-cycle expectations from a run-length reference model, queued and checked by a monitor.
// Latency: the expectation for each clock edge is pushed before the edge and popped 1 ns after it.
// Backpressure: not applicable; the DUT presents a new output state every cycle.
module tb_lr_car_detector;

    localparam int DEBOUNCE      = 3;
    localparam int DEPART_CYCLES = 2;
    localparam int QW            = 4;
    localparam int QMAX          = (1 << QW) - 1;

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sensor = 1'b0;
    logic [2:0]    lr_light = RED;
    logic          lr_has_car;
    logic [QW-1:0] car_count;
    logic          arrival_pulse;
    logic          overflow;

    lr_car_detector #(
        .DEBOUNCE     (DEBOUNCE),
        .DEPART_CYCLES(DEPART_CYCLES),
        .QW           (QW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor       (sensor),
        .lr_light     (lr_light),
        .lr_has_car   (lr_has_car),
        .car_count    (car_count),
        .arrival_pulse(arrival_pulse),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [QW-1:0] cnt;
        logic          has;
        logic          pulse;
        logic          ovf;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: sensor history, accepted vehicle level with the
    // length of the current run of opposite samples, green streak, queue size.
    int m_h1, m_h2, m_level, m_run, m_grun, m_cnt, m_ovf;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_level = 0; m_run = 0;
        m_grun = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Apply inputs for the next rising edge and queue the state expected after it.
    task automatic step(input logic sen, input logic [2:0] light, input logic rst);
        int   s;
        int   arr;
        int   dep;
        int   grn;
        exp_t e;
        @(negedge clk);
        sensor   = sen;
        lr_light = light;
        rst_n    = ~rst;
        if (rst) begin
            model_reset();
            arr = 0;
        end else begin
            s    = m_h2;
            m_h2 = m_h1;
            m_h1 = int'(sen);
            arr  = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DEBOUNCE) begin
                    m_level = s;
                    m_run   = 0;
                    arr     = s;
                end
            end else begin
                m_run = 0;
            end
            grn = (light == GREEN) ? 1 : 0;
            dep = (grn == 1 && m_cnt > 0 && m_grun == DEPART_CYCLES - 1) ? 1 : 0;
            if (grn == 0 || m_cnt == 0 || dep == 1) m_grun = 0;
            else m_grun++;
            if (arr == 1 && dep == 0) begin
                if (m_cnt == QMAX) m_ovf = 1;
                else m_cnt++;
            end else if (dep == 1 && arr == 0) begin
                m_cnt--;
            end
        end
        e.cnt   = QW'(m_cnt);
        e.has   = (m_cnt != 0);
        e.pulse = (arr != 0);
        e.ovf   = (m_ovf != 0);
        expq.push_back(e);
    endtask

    task automatic run(input logic sen, input logic [2:0] light, input int n);
        repeat (n) step(sen, light, 1'b0);
    endtask

    task automatic car(input logic [2:0] light, input int hi, input int lo);
        run(1'b1, light, hi);
        run(1'b0, light, lo);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, RED, 1'b1);
    endtask

    // Fixed-value check of the state after the edge that the last step() targeted.
    task automatic dcheck(input string name, input int act_sel, input int exp);
        @(posedge clk);
        #2;
        case (act_sel)
            0:       check(name, int'(car_count), exp);
            1:       check(name, int'(overflow), exp);
            default: check(name, int'(arrival_pulse), exp);
        endcase
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("car_count", int'(car_count), int'(e.cnt));
                check("lr_has_car", int'(lr_has_car), int'(e.has));
                check("arrival_pulse", int'(arrival_pulse), int'(e.pulse));
                check("overflow", int'(overflow), int'(e.ovf));
            end
        end
    end

    initial begin : stimulus
        model_reset();

        // Reset held with a toggling sensor, then released under red.
        for (int i = 0; i < 6; i++) step(logic'(i % 2), RED, 1'b1);
        run(1'b0, RED, 5);

        // Single car, then a second car.
        car(RED, 10, 10);
        dcheck("single_car_count", 0, 1);
        car(RED, 10, 10);
        dcheck("second_car_count", 0, 2);

        // Glitches of 1 and 2 cycles are rejected.
        do_reset(2);
        car(RED, 1, 5);
        car(RED, 2, 5);
        car(RED, 1, 5);
        dcheck("glitch_count", 0, 0);

        // Short dip while present does not count twice.
        run(1'b1, RED, 8);
        run(1'b0, RED, 2);
        run(1'b1, RED, 8);
        run(1'b0, RED, 8);
        dcheck("dip_count", 0, 1);

        // Drain of three cars over seven green cycles.
        do_reset(2);
        repeat (3) car(RED, 6, 6);
        run(1'b0, GREEN, 7);
        dcheck("drain_count", 0, 0);

        // Yellow mid-drain freezes the count and clears the timer.
        repeat (3) car(RED, 6, 6);
        run(1'b0, GREEN, 3);
        run(1'b0, YELLOW, 2);
        dcheck("yellow_freeze", 0, 2);
        run(1'b0, GREEN, 2);
        dcheck("after_yellow", 0, 1);

        // Arrival on a departure edge leaves the count unchanged.
        do_reset(2);
        car(RED, 6, 6);
        run(1'b1, RED, 3);
        run(1'b1, GREEN, 2);
        dcheck("simul_count", 0, 1);
        run(1'b1, RED, 3);
        run(1'b0, RED, 8);

        // Saturation then full drain; overflow stays set.
        do_reset(2);
        repeat (16) car(RED, 6, 6);
        dcheck("sat_count", 0, QMAX);
        dcheck("sat_ovf", 1, 1);
        run(1'b0, GREEN, 30);
        dcheck("sat_drain", 0, 0);
        dcheck("sat_ovf_sticky", 1, 1);

        // Reset mid-vehicle: a sensor still high afterwards is a new car.
        do_reset(2);
        run(1'b1, RED, 3);
        step(1'b1, RED, 1'b1);
        step(1'b1, RED, 1'b1);
        run(1'b1, RED, 8);
        dcheck("reset_mid_car", 0, 1);
        run(1'b0, RED, 8);

        // Randomised runs of sensor levels and light codes, including illegal ones.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] light;
            int         sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: light = RED;
                4, 5, 6:    light = GREEN;
                7:          light = YELLOW;
                8:          light = 3'b000;
                default:    light = 3'b110;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                run(logic'($urandom_range(0, 1)), light, int'($urandom_range(1, 10)));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
